// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Purpose  : Shared types and constants for the two-requester memory port
//            arbiter (sequencer state, owner encoding, latency counter width).
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Transaction sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Owner encoding, also used as the round-robin pointer value
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // Wide enough to hold READ_LAT-1 for the supported latency range 1..4
    localparam int LAT_CNT_W = 3;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Purpose  : Combinational winner selection between the CPU and the debug
//            requester. A lone eligible requester always wins; a tie goes to
//            debug under fixed priority, otherwise to the side the
//            round-robin pointer names.
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int DEBUG_PRIO = 1
) (
    input  logic i_cpu_elig,
    input  logic i_dbg_elig,
    input  logic i_rr_prefer,
    output logic o_grant_valid,
    output logic o_winner
);

    // Tie resolution: fixed debug priority or the round-robin preference
    always_comb begin
        o_grant_valid = i_cpu_elig | i_dbg_elig;
        o_winner      = OWN_CPU;
        if (i_cpu_elig && i_dbg_elig) begin
            o_winner = (DEBUG_PRIO != 0) ? OWN_DBG : i_rr_prefer;
        end else if (i_dbg_elig) begin
            o_winner = OWN_DBG;
        end
    end

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous memory port between the CPU data side
//            and the UART debug controller. One transaction in flight at a
//            time: grant (IDLE) -> one-cycle chip select (ISSUE) -> optional
//            read latency (WAIT) -> one-cycle ack (RESP). A lock input keeps
//            the CPU out while the debug side loads a program.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int DEBUG_PRIO = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  lock,
    // CPU requester
    input  logic                  c_req,
    input  logic [DATA_W/8-1:0]   c_we,
    input  logic [ADDR_W-1:0]     c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    output logic                  c_ack,
    output logic [DATA_W-1:0]     c_rdata,
    // Debug requester
    input  logic                  d_req,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    // Memory side
    output logic                  mem_cs,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    // Status
    output logic                  busy,
    output logic                  owner
);

    localparam int BE_W = DATA_W / 8;

    // WAIT lasts READ_LAT cycles, so the counter starts at READ_LAT-1 and
    // the read data is captured when it reaches zero.
    localparam logic [LAT_CNT_W-1:0] C_WAIT_LOAD = LAT_CNT_W'(READ_LAT - 1);

    // ------------------------------------------------------------------
    // Arbitration inputs and winner-side request mux
    // ------------------------------------------------------------------
    logic              w_cpu_elig;
    logic              w_dbg_elig;
    logic              w_grant_valid;
    logic              w_winner;
    logic [BE_W-1:0]   w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // ------------------------------------------------------------------
    // Sequencer and output registers
    // ------------------------------------------------------------------
    arb_state_t           r_state;
    logic                 r_owner;
    logic                 r_rr_prefer;
    logic                 r_is_write;
    logic [LAT_CNT_W-1:0] r_wait_cnt;
    logic                 r_mem_cs;
    logic [BE_W-1:0]      r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic                 r_c_ack;
    logic                 r_d_ack;
    logic [DATA_W-1:0]    r_c_rdata;
    logic [DATA_W-1:0]    r_d_rdata;

    // The lock only masks the CPU; debug is always eligible when requesting
    assign w_cpu_elig = c_req & ~lock;
    assign w_dbg_elig = d_req;

    arb_pick #(
        .DEBUG_PRIO (DEBUG_PRIO)
    ) u_arb_pick (
        .i_cpu_elig    (w_cpu_elig),
        .i_dbg_elig    (w_dbg_elig),
        .i_rr_prefer   (r_rr_prefer),
        .o_grant_valid (w_grant_valid),
        .o_winner      (w_winner)
    );

    assign w_sel_we    = (w_winner == OWN_DBG) ? d_we    : c_we;
    assign w_sel_addr  = (w_winner == OWN_DBG) ? d_addr  : c_addr;
    assign w_sel_wdata = (w_winner == OWN_DBG) ? d_wdata : c_wdata;

    // Transaction sequencer: grant, issue, read wait, ack; all outputs registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_rr_prefer <= OWN_CPU;
            r_is_write  <= 1'b0;
            r_wait_cnt  <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_c_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_c_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_c_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    if (w_grant_valid) begin
                        // Capture the winner's request so the requester may
                        // drop req afterwards without disturbing the access.
                        r_owner     <= w_winner;
                        r_rr_prefer <= ~w_winner;
                        r_is_write  <= (w_sel_we != '0);
                        r_mem_cs    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Chip select is a single-cycle pulse; byte enables are
                    // cleared with it so they never appear without cs.
                    r_mem_cs <= 1'b0;
                    r_mem_we <= '0;
                    if (r_is_write) begin
                        r_c_ack <= (r_owner == OWN_CPU);
                        r_d_ack <= (r_owner == OWN_DBG);
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= C_WAIT_LOAD;
                        r_state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        // Last wait cycle: memory data is valid now. Only the
                        // owner's read-data register is touched.
                        if (r_owner == OWN_DBG) begin
                            r_d_rdata <= mem_rdata;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_c_rdata <= mem_rdata;
                            r_c_ack   <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end

                RESP: begin
                    r_c_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign c_ack     = r_c_ack;
    assign d_ack     = r_d_ack;
    assign c_rdata   = r_c_rdata;
    assign d_rdata   = r_d_rdata;
    assign owner     = r_owner;
    assign busy      = (r_state != IDLE);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench. Instance A (debug priority, read latency 1)
//            runs a vector table and directed sequences; instance B
//            (round-robin, read latency 2) runs a round-robin sequence and
//            random traffic checked by a cycle-offset reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int B_LAT  = 2;
    localparam int B_PRIO = 0;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A signals ----------------
    logic        a_lock = 0, a_c_req = 0, a_d_req = 0;
    logic [3:0]  a_c_we = 0, a_d_we = 0;
    logic [31:0] a_c_addr = 0, a_c_wdata = 0, a_d_addr = 0, a_d_wdata = 0;
    logic        a_c_ack, a_d_ack, a_mem_cs, a_busy, a_owner;
    logic [31:0] a_c_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_we;

    // ---------------- instance B signals ----------------
    logic        b_lock = 0, b_c_req = 0, b_d_req = 0;
    logic [3:0]  b_c_we = 0, b_d_we = 0;
    logic [31:0] b_c_addr = 0, b_c_wdata = 0, b_d_addr = 0, b_d_wdata = 0;
    logic        b_c_ack, b_d_ack, b_mem_cs, b_busy, b_owner;
    logic [31:0] b_c_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_we;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .DEBUG_PRIO(1)) dut_a (
        .CLK(CLK), .RST(RST), .lock(a_lock),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
        .c_ack(a_c_ack), .c_rdata(a_c_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .mem_cs(a_mem_cs), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(B_LAT), .DEBUG_PRIO(B_PRIO)) dut_b (
        .CLK(CLK), .RST(RST), .lock(b_lock),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_ack(b_c_ack), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .owner(b_owner)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        merge = old;
        for (int b = 0; b < 4; b++) if (we[b]) merge[8*b +: 8] = wd[8*b +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory models ----------------
    logic [31:0] mem_a [0:63] = '{default: 32'h0};
    logic [31:0] a_rd_q = 32'h0;
    always @(posedge CLK) begin
        a_rd_q <= (a_mem_cs && a_mem_we == 4'h0) ? mem_a[a_mem_addr[5:0]] : $urandom;
        if (a_mem_cs && a_mem_we != 4'h0)
            mem_a[a_mem_addr[5:0]] <= merge(mem_a[a_mem_addr[5:0]], a_mem_wdata, a_mem_we);
    end
    assign a_mem_rdata = a_rd_q;

    logic [31:0] mem_b [0:15] = '{default: 32'h0};
    logic [31:0] b_rd0 = 32'h0, b_rd1 = 32'h0;
    always @(posedge CLK) begin
        b_rd0 <= (b_mem_cs && b_mem_we == 4'h0) ? mem_b[b_mem_addr[3:0]] : $urandom;
        b_rd1 <= b_rd0;
        if (b_mem_cs && b_mem_we != 4'h0)
            mem_b[b_mem_addr[3:0]] <= merge(mem_b[b_mem_addr[3:0]], b_mem_wdata, b_mem_we);
    end
    assign b_mem_rdata = b_rd1;

    // ---------------- reference model for instance B ----------------
    // Tracks the cycle offset from the grant cycle: chip select at offset 1,
    // ack at offset 2 (write) or 2+latency (read), then idle again.
    logic        b_model_on = 0;
    int          m_off = 0, m_ack_off = 0;
    logic        m_own = 0, m_last = 1, m_ce, m_de;
    logic [3:0]  m_we = 0;
    logic [31:0] m_addr = 0, m_wd = 0, m_c_rd = 0, m_d_rd = 0;
    logic [31:0] shadow_b [0:15] = '{default: 32'h0};
    logic        b_log_on = 0;
    logic        grant_log [$];

    always @(negedge CLK) begin
        if (b_log_on && b_mem_cs) grant_log.push_back(b_owner);
        if (b_model_on) begin
            if (m_off == 0) begin
                chk("b_idle_busy", 32'(b_busy), 0);
                chk("b_idle_cs", 32'(b_mem_cs), 0);
                chk("b_idle_acks", {30'h0, b_c_ack, b_d_ack}, 0);
                m_ce = b_c_req && !b_lock;
                m_de = b_d_req;
                if (m_ce || m_de) begin
                    if (m_ce && m_de) m_own = (B_PRIO != 0) ? 1'b1 : ~m_last;
                    else              m_own = m_de;
                    m_last    = m_own;
                    m_we      = m_own ? b_d_we    : b_c_we;
                    m_addr    = m_own ? b_d_addr  : b_c_addr;
                    m_wd      = m_own ? b_d_wdata : b_c_wdata;
                    m_ack_off = (m_we != 0) ? 2 : 2 + B_LAT;
                    m_off     = 1;
                end
            end else begin
                chk("b_busy", 32'(b_busy), 1);
                chk("b_owner", 32'(b_owner), 32'(m_own));
                chk("b_cs", 32'(b_mem_cs), 32'(m_off == 1));
                if (m_off == 1) begin
                    chk("b_mem_we", 32'(b_mem_we), 32'(m_we));
                    chk("b_mem_addr", b_mem_addr, m_addr);
                    chk("b_mem_wdata", b_mem_wdata, m_wd);
                end
                if (m_off == m_ack_off) begin
                    if (m_we == 0) begin
                        if (m_own) m_d_rd = shadow_b[m_addr[3:0]];
                        else       m_c_rd = shadow_b[m_addr[3:0]];
                    end else begin
                        shadow_b[m_addr[3:0]] = merge(shadow_b[m_addr[3:0]], m_wd, m_we);
                    end
                end
                chk("b_c_ack", 32'(b_c_ack), 32'(m_off == m_ack_off && !m_own));
                chk("b_d_ack", 32'(b_d_ack), 32'(m_off == m_ack_off && m_own));
                m_off = (m_off == m_ack_off) ? 0 : m_off + 1;
            end
            chk("b_c_rdata", b_c_rdata, m_c_rd);
            chk("b_d_rdata", b_d_rdata, m_d_rd);
        end
    end

    // ---------------- instance A helpers ----------------
    typedef struct {
        logic        dbg;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_ack;
        logic        drop;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_c_rd = 0, exp_d_rd = 0;

    task automatic a_drive(input logic dbg, input logic req, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wd);
        if (dbg) begin a_d_req = req; a_d_we = we; a_d_addr = addr; a_d_wdata = wd; end
        else     begin a_c_req = req; a_c_we = we; a_c_addr = addr; a_c_wdata = wd; end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int cs_cnt = 0, cs_at = -1, ack_cnt = 0, ack_at = -1, other = 0, busy_bad = 0;
        logic fields_ok = 1;
        logic own_ack, oth_ack;
        @(posedge CLK); #1;
        a_drive(v.dbg, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (a_mem_cs) begin
                cs_cnt++; cs_at = k;
                if (a_mem_we !== v.we || a_mem_addr !== v.addr || a_mem_wdata !== v.wdata)
                    fields_ok = 0;
            end
            own_ack = v.dbg ? a_d_ack : a_c_ack;
            oth_ack = v.dbg ? a_c_ack : a_d_ack;
            if (own_ack) begin ack_cnt++; if (ack_at < 0) ack_at = k; end
            if (oth_ack) other++;
            if (a_busy !== (k >= 1 && k <= v.exp_ack)) busy_bad++;
            @(posedge CLK); #1;
            if ((v.drop && k == 0) || k == ack_at) a_drive(v.dbg, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        if (v.we == 4'h0) begin
            if (v.dbg) exp_d_rd = v.exp_rd; else exp_c_rd = v.exp_rd;
        end
        chk({tag, "_cs_count"}, cs_cnt, 1);
        chk({tag, "_cs_cycle"}, cs_at, 1);
        chk({tag, "_cs_fields"}, 32'(fields_ok), 1);
        chk({tag, "_ack_count"}, ack_cnt, 1);
        chk({tag, "_ack_cycle"}, ack_at, v.exp_ack);
        chk({tag, "_other_ack"}, other, 0);
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_owner"}, 32'(a_owner), 32'(v.dbg));
        chk({tag, "_c_rdata"}, a_c_rdata, exp_c_rd);
        chk({tag, "_d_rdata"}, a_d_rdata, exp_d_rd);
    endtask

    // ---------------- instance B requester ----------------
    task automatic b_drive(input logic dbg, input logic req, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wd);
        if (dbg) begin b_d_req = req; b_d_we = we; b_d_addr = addr; b_d_wdata = wd; end
        else     begin b_c_req = req; b_c_we = we; b_c_addr = addr; b_c_wdata = wd; end
    endtask

    task automatic b_requester(input logic dbg, input int n, input logic rnd, output int acks);
        int          gap, w;
        logic        got;
        logic [3:0]  we;
        logic [31:0] addr, wd;
        acks = 0;
        for (int t = 0; t < n; t++) begin
            gap = rnd ? int'($urandom_range(0, 3)) : 0;
            if (rnd) begin
                we   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                addr = 32'($urandom_range(0, 15));
                wd   = $urandom;
            end else begin
                we   = 4'hF;
                addr = dbg ? 32'h1 : 32'h2;
                wd   = {16'(t), 16'(dbg)};
            end
            if (gap > 0) begin
                b_drive(dbg, 1'b0, 4'h0, 32'h0, 32'h0);
                repeat (gap) begin @(posedge CLK); #1; end
            end
            b_drive(dbg, 1'b1, we, addr, wd);
            got = 0; w = 0;
            while (!got && w < 300) begin
                @(negedge CLK);
                if (dbg ? b_d_ack : b_c_ack) got = 1; else w++;
                @(posedge CLK); #1;
            end
            chk(dbg ? "b_dbg_ack_seen" : "b_cpu_ack_seen", 32'(got), 1);
            if (got) acks++;
        end
        b_drive(dbg, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int   cs_n, ca_n, da_n, bad_own, cs_at, ack_at, ca, da;
        logic c_done, d_done;

        vecs[0] = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        2, 1'b0};
        vecs[1] = '{1'b1, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF, 3, 1'b0};
        vecs[2] = '{1'b0, 4'h3, 32'h10, 32'h12345678, 32'h0,        2, 1'b1};
        vecs[3] = '{1'b1, 4'hC, 32'h20, 32'hAABBCCDD, 32'h0,        2, 1'b0};
        vecs[4] = '{1'b0, 4'h0, 32'h10, 32'h0,        32'hDEAD5678, 3, 1'b0};
        vecs[5] = '{1'b0, 4'h0, 32'h20, 32'h0,        32'hAABB0000, 3, 1'b1};
        vecs[6] = '{1'b1, 4'h1, 32'h10, 32'h11223344, 32'h0,        2, 1'b0};
        vecs[7] = '{1'b1, 4'h0, 32'h10, 32'h0,        32'hDEAD5644, 3, 1'b0};

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_a_outputs", {24'h0, a_mem_cs, a_c_ack, a_d_ack, a_busy, a_owner, 3'b0}, 0);
        chk("rst_a_mem_bus", a_mem_addr | a_mem_wdata | 32'(a_mem_we), 0);
        chk("rst_a_rdata", a_c_rdata | a_d_rdata, 0);
        chk("rst_b_outputs", {24'h0, b_mem_cs, b_c_ack, b_d_ack, b_busy, b_owner, 3'b0}, 0);
        @(posedge CLK); #1;
        RST = 0;

        // Vector table on instance A
        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Tie with debug priority: debug wins every time while requesting
        cs_n = 0; ca_n = 0; da_n = 0; bad_own = 0;
        @(posedge CLK); #1;
        a_drive(1'b0, 1'b1, 4'hF, 32'h08, 32'h01010101);
        a_drive(1'b1, 1'b1, 4'hF, 32'h0C, 32'h02020202);
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (a_mem_cs) begin cs_n++; if (a_owner !== 1'b1) bad_own++; end
            if (a_c_ack) ca_n++;
            if (a_d_ack) da_n++;
            @(posedge CLK); #1;
        end
        a_drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("prio_cpu_acks", ca_n, 0);
        chk("prio_dbg_acks", da_n, 10);
        chk("prio_owner", bad_own, 0);
        ack_at = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (a_c_ack && ack_at < 0) ack_at = k;
            @(posedge CLK); #1;
            if (k == ack_at) a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        chk("prio_cpu_after_dbg", ack_at, 2);

        // Lock holds the CPU off
        cs_n = 0; ca_n = 0;
        a_lock = 1;
        a_drive(1'b0, 1'b1, 4'hF, 32'h04, 32'h0BADF00D);
        repeat (20) begin
            @(negedge CLK);
            if (a_mem_cs) cs_n++;
            if (a_c_ack) ca_n++;
            @(posedge CLK); #1;
        end
        chk("lock_no_cs", cs_n, 0);
        chk("lock_no_ack", ca_n, 0);
        a_lock = 0;
        cs_at = -1; ack_at = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (a_mem_cs && cs_at < 0) cs_at = k;
            if (a_c_ack && ack_at < 0) ack_at = k;
            @(posedge CLK); #1;
            if (k == ack_at) a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        chk("unlock_cs_cycle", cs_at, 1);
        chk("unlock_ack_cycle", ack_at, 2);

        // Lock raised during the CPU's ISSUE cycle: access still completes
        a_drive(1'b0, 1'b1, 4'hF, 32'h18, 32'h55AA55AA);
        cs_n = 0; ack_at = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (a_mem_cs) cs_n++;
            if (a_c_ack && ack_at < 0) ack_at = k;
            @(posedge CLK); #1;
            if (k == 0) a_lock = 1;
        end
        chk("lock_mid_ack_cycle", ack_at, 2);
        chk("lock_mid_cs_count", cs_n, 1);
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        a_lock = 0;

        // Reset in the WAIT cycle of a CPU read
        @(posedge CLK); #1;
        a_drive(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge CLK); @(posedge CLK); #1;
        @(negedge CLK);
        chk("rstmid_issue_cs", 32'(a_mem_cs), 1);
        @(posedge CLK); #1;
        RST = 1;
        @(negedge CLK); @(posedge CLK); #1;
        RST = 0;
        a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("rstmid_outputs", {24'h0, a_mem_cs, a_c_ack, a_d_ack, a_busy, a_owner, 3'b0}, 0);
        chk("rstmid_mem_bus", a_mem_addr | a_mem_wdata | 32'(a_mem_we), 0);
        chk("rstmid_rdata", a_c_rdata | a_d_rdata, 0);
        ca_n = 0;
        repeat (6) begin @(posedge CLK); #1; @(negedge CLK); if (a_c_ack) ca_n++; end
        chk("rstmid_no_ack", ca_n, 0);
        exp_c_rd = 0; exp_d_rd = 0;
        run_txn('{1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD5644, 3, 1'b0}, "after_rst");

        // Instance B: fresh reset, then round-robin tie of 4 writes each
        @(posedge CLK); #1; RST = 1;
        @(posedge CLK); #1; RST = 0;
        b_model_on = 1;
        b_log_on   = 1;
        fork
            b_requester(1'b0, 4, 1'b0, ca);
            b_requester(1'b1, 4, 1'b0, da);
        join
        b_log_on = 0;
        chk("rr_total_acks", ca + da, 8);
        chk("rr_grant_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++)
            chk($sformatf("rr_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

        // Instance B: random traffic with random lock phases
        c_done = 0; d_done = 0;
        fork
            begin b_requester(1'b0, 40, 1'b1, ca); c_done = 1; end
            begin b_requester(1'b1, 40, 1'b1, da); d_done = 1; end
            begin
                while (!(c_done && d_done)) begin
                    b_lock = ($urandom_range(0, 3) == 0);
                    repeat ($urandom_range(1, 12)) begin @(posedge CLK); #1; end
                end
                b_lock = 0;
            end
        join
        chk("rand_cpu_acks", ca, 40);
        chk("rand_dbg_acks", da, 40);
        repeat (10) @(posedge CLK);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
